decode_stage: RTL and testbench

- Registered, parametrised instruction-decode stage for the RV32I pipeline. It sits between fetch and execute.
- Accepts one instruction per cycle under a valid/ready handshake and decodes it into control, register-index and XLEN-wide sign-extended immediate fields.
- Holds the decoded result in an output register.
- Enforces load-use interlock with a configurable bubble count, and supports a synchronous flush for taken branches and jumps.

---
 rtl/decode_pkg.sv | 103 ++++++++++
 rtl/imm_gen.sv | 35 +++
 rtl/decode_stage.sv | 246 ++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared RV32I decode constants, formats and bundle types.
// Imported by imm_gen and decode_stage.
package decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SRL_SRA = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_SLL   = 5'd2;
    localparam logic [4:0] ALU_SLT   = 5'd3;
    localparam logic [4:0] ALU_SLTU  = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_OR    = 5'd8;
    localparam logic [4:0] ALU_AND   = 5'd9;
    localparam logic [4:0] ALU_PASSB = 5'd10;

    localparam logic [1:0] XFER_BYTE = 2'd0;
    localparam logic [1:0] XFER_HALF = 2'd1;
    localparam logic [1:0] XFER_WORD = 2'd2;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_ILLEGAL
    } fmt_e;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [4:0] alu_op;
        logic       use_imm;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic [1:0] xfer_size;
        logic       load_unsigned;
        logic       illegal;
    } dec_t;

    function automatic logic fmt_uses_rs1(input fmt_e f);
        return (f == FMT_R) || (f == FMT_I) ||
               (f == FMT_S) || (f == FMT_B);
    endfunction

    function automatic logic fmt_uses_rs2(input fmt_e f);
        return (f == FMT_R) || (f == FMT_S) || (f == FMT_B);
    endfunction

    function automatic logic fmt_writes_rd(input fmt_e f);
        return (f == FMT_R) || (f == FMT_I) ||
               (f == FMT_U) || (f == FMT_J);
    endfunction

    // alt selects SUB / SRA variants of the shared funct3 space
    function automatic logic [4:0] alu_from_f3(
        input logic [2:0] f3,
        input logic       alt
    );
        logic [4:0] op;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: reassembles the RV32I immediate for a given format and
// sign-extends it to XLEN bits.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
)(
    input  logic [31:0]     i_instr,
    input  fmt_e            i_fmt,
    output logic [XLEN-1:0] o_imm
);

    logic [31:0] w_imm32;

    // Gather the scattered immediate bits into a 32-bit signed value
    always_comb begin
        w_imm32 = '0;
        unique case (i_fmt)
            FMT_I: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            FMT_S: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25],
                              i_instr[11:7]};
            FMT_B: w_imm32 = {{19{i_instr[31]}}, i_instr[31],
                              i_instr[7], i_instr[30:25],
                              i_instr[11:8], 1'b0};
            FMT_U: w_imm32 = {i_instr[31:12], 12'b0};
            FMT_J: w_imm32 = {{11{i_instr[31]}}, i_instr[31],
                              i_instr[19:12], i_instr[20],
                              i_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode with valid/ready handshake,
// load-use interlock and synchronous flush.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
)(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_use_imm,
    output logic [4:0]       out_alu_op,
    output logic             out_reg_write,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic             out_branch,
    output logic             out_jal,
    output logic             out_jalr,
    output logic [1:0]       out_xfer_size,
    output logic             out_load_unsigned,
    output logic             out_illegal,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int HOLD_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(LOAD_LAT - 1);

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    fmt_e            w_fmt;
    dec_t            w_dec;
    logic            w_shift;
    logic [XLEN-1:0] w_imm_raw;
    logic [XLEN-1:0] w_imm;
    logic            w_hit_out;
    logic            w_hit_trk;
    logic            w_hazard;
    logic            w_in_fire;
    logic            w_out_fire;

    logic              r_valid;
    dec_t              r_out;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_imm;
    logic [4:0]        r_trk_rd;
    logic [HOLD_W-1:0] r_hold;
    logic [CNT_W-1:0]  r_stall;

    assign w_opcode = in_instr[6:0];
    assign w_f3     = in_instr[14:12];
    assign w_f7     = in_instr[31:25];

    // Classify the instruction and derive its control bundle
    always_comb begin
        w_fmt   = FMT_ILLEGAL;
        w_dec   = '0;
        w_shift = 1'b0;
        unique case (w_opcode)
            OPC_LUI: begin
                w_fmt = FMT_U;
                w_dec.alu_op    = ALU_PASSB;
                w_dec.use_imm   = 1'b1;
                w_dec.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                w_fmt = FMT_U;
                w_dec.alu_op    = ALU_ADD;
                w_dec.use_imm   = 1'b1;
                w_dec.reg_write = 1'b1;
            end
            OPC_JAL: begin
                w_fmt = FMT_J;
                w_dec.alu_op    = ALU_ADD;
                w_dec.use_imm   = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.jal       = 1'b1;
            end
            OPC_JALR: begin
                w_fmt = FMT_I;
                w_dec.alu_op    = ALU_ADD;
                w_dec.use_imm   = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.jalr      = 1'b1;
            end
            OPC_BRANCH: begin
                if (w_f3 != 3'd2 && w_f3 != 3'd3) begin
                    w_fmt = FMT_B;
                    w_dec.branch = 1'b1;
                    case (w_f3[2:1])
                        2'b10:   w_dec.alu_op = ALU_SLT;
                        2'b11:   w_dec.alu_op = ALU_SLTU;
                        default: w_dec.alu_op = ALU_SUB;
                    endcase
                end
            end
            OPC_LOAD: begin
                if (w_f3 != 3'd3 && w_f3 != 3'd6 && w_f3 != 3'd7) begin
                    w_fmt = FMT_I;
                    w_dec.alu_op        = ALU_ADD;
                    w_dec.use_imm       = 1'b1;
                    w_dec.reg_write     = 1'b1;
                    w_dec.mem_read      = 1'b1;
                    w_dec.xfer_size     = w_f3[1:0];
                    w_dec.load_unsigned = w_f3[2];
                end
            end
            OPC_STORE: begin
                if (w_f3 < 3'd3) begin
                    w_fmt = FMT_S;
                    w_dec.alu_op    = ALU_ADD;
                    w_dec.use_imm   = 1'b1;
                    w_dec.mem_write = 1'b1;
                    w_dec.xfer_size = w_f3[1:0];
                end
            end
            OPC_OP_IMM: begin
                w_fmt = FMT_I;
                w_shift = (w_f3 == F3_SLL) || (w_f3 == F3_SRL_SRA);
                w_dec.alu_op = alu_from_f3(
                    w_f3, (w_f3 == F3_SRL_SRA) && in_instr[30]);
                w_dec.use_imm   = 1'b1;
                w_dec.reg_write = 1'b1;
            end
            OPC_OP: begin
                if (w_f7 == F7_BASE ||
                    (w_f7 == F7_ALT &&
                     (w_f3 == F3_ADD_SUB || w_f3 == F3_SRL_SRA))) begin
                    w_fmt = FMT_R;
                    w_dec.alu_op    = alu_from_f3(w_f3, w_f7[5]);
                    w_dec.reg_write = 1'b1;
                end
            end
            default: w_fmt = FMT_ILLEGAL;
        endcase
        w_dec.illegal = (w_fmt == FMT_ILLEGAL);
        w_dec.rs1 = fmt_uses_rs1(w_fmt) ? in_instr[19:15] : 5'd0;
        w_dec.rs2 = fmt_uses_rs2(w_fmt) ? in_instr[24:20] : 5'd0;
        w_dec.rd  = fmt_writes_rd(w_fmt) ? in_instr[11:7] : 5'd0;
        if (w_dec.rd == 5'd0) begin
            w_dec.reg_write = 1'b0;
        end
    end

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .i_instr (in_instr),
        .i_fmt   (w_fmt),
        .o_imm   (w_imm_raw)
    );

    // Shift-immediates only carry the 5-bit shamt
    assign w_imm = w_shift ? {{(XLEN-5){1'b0}}, in_instr[24:20]}
                           : w_imm_raw;

    // Unused sources are zeroed, so they never match a nonzero rd
    assign w_hit_out = (r_out.rd != 5'd0) &&
                       (w_dec.rs1 == r_out.rd || w_dec.rs2 == r_out.rd);
    assign w_hit_trk = (r_trk_rd != 5'd0) &&
                       (w_dec.rs1 == r_trk_rd || w_dec.rs2 == r_trk_rd);

    assign w_hazard = in_valid &&
                      ((r_valid && r_out.mem_read && w_hit_out) ||
                       (r_hold != '0 && w_hit_trk));

    assign in_ready   = !flush && (!r_valid || out_ready) && !w_hazard;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_valid && out_ready;

    // Output register: flush, then accept, then drain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_out   <= '0;
            r_pc    <= '0;
            r_imm   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_in_fire) begin
            r_valid <= 1'b1;
            r_out   <= w_dec;
            r_pc    <= in_pc;
            r_imm   <= w_imm;
        end else if (w_out_fire) begin
            r_valid <= 1'b0;
        end
    end

    // Remember a departed load's rd for the remaining interlock cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_trk_rd <= '0;
            r_hold   <= '0;
        end else if (flush) begin
            r_hold <= '0;
        end else if (w_out_fire && r_out.mem_read && r_out.rd != 5'd0) begin
            r_trk_rd <= r_out.rd;
            r_hold   <= HOLD_INIT;
        end else if (r_hold != '0) begin
            r_hold <= r_hold - HOLD_W'(1);
        end
    end

    // Saturating count of cycles lost to the interlock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall <= '0;
        end else if (w_hazard && !flush && r_stall != {CNT_W{1'b1}}) begin
            r_stall <= r_stall + CNT_W'(1);
        end
    end

    assign out_valid         = r_valid;
    assign out_pc            = r_pc;
    assign out_imm           = r_imm;
    assign out_rs1           = r_out.rs1;
    assign out_rs2           = r_out.rs2;
    assign out_rd            = r_out.rd;
    assign out_use_imm       = r_out.use_imm;
    assign out_alu_op        = r_out.alu_op;
    assign out_reg_write     = r_out.reg_write;
    assign out_mem_read      = r_out.mem_read;
    assign out_mem_write     = r_out.mem_write;
    assign out_branch        = r_out.branch;
    assign out_jal           = r_out.jal;
    assign out_jalr          = r_out.jalr;
    assign out_xfer_size     = r_out.xfer_size;
    assign out_load_unsigned = r_out.load_unsigned;
    assign out_illegal       = r_out.illegal;
    assign stall_cycles      = r_stall;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode_stage with LOAD_LAT=1
// (u1) and LOAD_LAT=3 (u3) sharing the same stimulus.
module tb_decode_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_ready;

    logic        o1_in_ready, o1_valid, o1_use_imm, o1_rw, o1_mr, o1_mw;
    logic        o1_br, o1_jal, o1_jalr, o1_lu, o1_ill;
    logic [31:0] o1_pc, o1_imm;
    logic [4:0]  o1_rs1, o1_rs2, o1_rd, o1_alu;
    logic [1:0]  o1_xs;
    logic [15:0] o1_stall;

    logic        o3_in_ready, o3_valid, o3_use_imm, o3_rw, o3_mr, o3_mw;
    logic        o3_br, o3_jal, o3_jalr, o3_lu, o3_ill;
    logic [31:0] o3_pc, o3_imm;
    logic [4:0]  o3_rs1, o3_rs2, o3_rd, o3_alu;
    logic [1:0]  o3_xs;
    logic [15:0] o3_stall;

    int errs   = 0;
    int checks = 0;

    logic        sel;
    logic        s_rdy, s_valid;
    logic [4:0]  s_rd;
    logic [15:0] s_stall;
    assign s_rdy   = sel ? o3_in_ready : o1_in_ready;
    assign s_valid = sel ? o3_valid    : o1_valid;
    assign s_rd    = sel ? o3_rd       : o1_rd;
    assign s_stall = sel ? o3_stall    : o1_stall;

    decode_stage #(.XLEN(32), .LOAD_LAT(1), .CNT_W(16)) u1 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(o1_in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(o1_valid), .out_ready(out_ready),
        .out_pc(o1_pc), .out_rs1(o1_rs1), .out_rs2(o1_rs2),
        .out_rd(o1_rd), .out_imm(o1_imm), .out_use_imm(o1_use_imm),
        .out_alu_op(o1_alu), .out_reg_write(o1_rw),
        .out_mem_read(o1_mr), .out_mem_write(o1_mw),
        .out_branch(o1_br), .out_jal(o1_jal), .out_jalr(o1_jalr),
        .out_xfer_size(o1_xs), .out_load_unsigned(o1_lu),
        .out_illegal(o1_ill), .stall_cycles(o1_stall)
    );

    decode_stage #(.XLEN(32), .LOAD_LAT(3), .CNT_W(16)) u3 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(o3_in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(o3_valid), .out_ready(out_ready),
        .out_pc(o3_pc), .out_rs1(o3_rs1), .out_rs2(o3_rs2),
        .out_rd(o3_rd), .out_imm(o3_imm), .out_use_imm(o3_use_imm),
        .out_alu_op(o3_alu), .out_reg_write(o3_rw),
        .out_mem_read(o3_mr), .out_mem_write(o3_mw),
        .out_branch(o3_br), .out_jal(o3_jal), .out_jalr(o3_jalr),
        .out_xfer_size(o3_xs), .out_load_unsigned(o3_lu),
        .out_illegal(o3_ill), .stall_cycles(o3_stall)
    );

    localparam logic [31:0] I_ADD  = 32'h005686b3;
    localparam logic [31:0] I_ADDI = 32'hfe010113;
    localparam logic [31:0] I_BEQ  = 32'h02d50463;
    localparam logic [31:0] I_JAL  = 32'h19c000ef;
    localparam logic [31:0] I_LW   = 32'h00012503;
    localparam logic [31:0] I_DEP  = 32'h00a505b3;
    localparam logic [31:0] I_SRAI = 32'h40355513;
    localparam logic [31:0] I_SUB  = 32'h405686b3;

    task automatic do_reset();
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_pc     = 32'h0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (o1_valid !== 1'b0) begin
            errs++; $display("FAIL reset_valid: got %b want 0", o1_valid);
        end
        checks++;
        if (o1_rd !== 5'd0 || o1_imm !== 32'h0 || o1_pc !== 32'h0) begin
            errs++; $display("FAIL reset_fields: got rd=%0d imm=%h pc=%h want 0",
                             o1_rd, o1_imm, o1_pc);
        end
        checks++;
        if (o1_stall !== 16'd0 || o3_stall !== 16'd0) begin
            errs++; $display("FAIL reset_stall: got %0d/%0d want 0", o1_stall, o3_stall);
        end
        checks++;
        if (o1_in_ready !== 1'b1) begin
            errs++; $display("FAIL reset_in_ready: got %b want 1", o1_in_ready);
        end
    endtask

    task automatic test_rtype();
        do_reset();
        in_valid = 1'b1; in_instr = I_ADD; in_pc = 32'h100; out_ready = 1'b1;
        #1;
        checks++;
        if (o1_in_ready !== 1'b1) begin
            errs++; $display("FAIL rtype_ready: got %b want 1", o1_in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (o1_valid !== 1'b1 || o1_rd !== 5'd13 || o1_rs1 !== 5'd13 ||
            o1_rs2 !== 5'd5 || o1_pc !== 32'h100) begin
            errs++; $display("FAIL rtype_regs: got v=%b rd=%0d rs1=%0d rs2=%0d pc=%h want 1/13/13/5/100",
                             o1_valid, o1_rd, o1_rs1, o1_rs2, o1_pc);
        end
        checks++;
        if (o1_alu !== 5'd0 || o1_rw !== 1'b1 || o1_use_imm !== 1'b0) begin
            errs++; $display("FAIL rtype_ctrl: got alu=%0d rw=%b ui=%b want 0/1/0",
                             o1_alu, o1_rw, o1_use_imm);
        end
        @(posedge clk); #1;
        checks++;
        if (o1_valid !== 1'b0) begin
            errs++; $display("FAIL rtype_drain: got %b want 0", o1_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        in_instr = I_ADDI; in_pc = 32'h200;
        @(posedge clk); #1;
        in_instr = I_BEQ; in_pc = 32'h204;
        checks++;
        if (o1_imm !== 32'hffffffe0 || o1_use_imm !== 1'b1 ||
            o1_rd !== 5'd2 || o1_rw !== 1'b1) begin
            errs++; $display("FAIL addi: got imm=%h ui=%b rd=%0d rw=%b want ffffffe0/1/2/1",
                             o1_imm, o1_use_imm, o1_rd, o1_rw);
        end
        #1;
        checks++;
        if (o1_in_ready !== 1'b1) begin
            errs++; $display("FAIL b2b_ready1: got %b want 1", o1_in_ready);
        end
        @(posedge clk); #1;
        in_instr = I_JAL; in_pc = 32'h208;
        checks++;
        if (o1_valid !== 1'b1 || o1_imm !== 32'h28 || o1_br !== 1'b1 ||
            o1_rw !== 1'b0 || o1_rd !== 5'd0 || o1_rs1 !== 5'd10 ||
            o1_rs2 !== 5'd13 || o1_pc !== 32'h204) begin
            errs++; $display("FAIL beq: got v=%b imm=%h br=%b rw=%b rd=%0d rs=%0d,%0d pc=%h want 1/28/1/0/0/10,13/204",
                             o1_valid, o1_imm, o1_br, o1_rw, o1_rd, o1_rs1, o1_rs2, o1_pc);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (o1_valid !== 1'b1 || o1_imm !== 32'h19c || o1_jal !== 1'b1 ||
            o1_rd !== 5'd1 || o1_rw !== 1'b1 || o1_br !== 1'b0 ||
            o1_rs1 !== 5'd0 || o1_pc !== 32'h208) begin
            errs++; $display("FAIL jal: got v=%b imm=%h jal=%b rd=%0d rw=%b br=%b rs1=%0d pc=%h want 1/19c/1/1/1/0/0/208",
                             o1_valid, o1_imm, o1_jal, o1_rd, o1_rw, o1_br, o1_rs1, o1_pc);
        end
    endtask

    task automatic test_shift_sub();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = I_SRAI;
        @(posedge clk); #1;
        in_instr = I_SUB;
        checks++;
        if (o1_alu !== 5'd7 || o1_imm !== 32'h3 || o1_use_imm !== 1'b1 ||
            o1_rd !== 5'd10) begin
            errs++; $display("FAIL srai: got alu=%0d imm=%h ui=%b rd=%0d want 7/3/1/10",
                             o1_alu, o1_imm, o1_use_imm, o1_rd);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (o1_alu !== 5'd1 || o1_ill !== 1'b0 || o1_rw !== 1'b1) begin
            errs++; $display("FAIL sub: got alu=%0d ill=%b rw=%b want 1/0/1",
                             o1_alu, o1_ill, o1_rw);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] vec [3];
        vec[0] = 32'hffffffff;
        vec[1] = 32'h405696b3;
        vec[2] = 32'h00013503;
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_instr = vec[k];
            @(posedge clk); #1;
            checks++;
            if (o1_valid !== 1'b1 || o1_ill !== 1'b1 || o1_rw !== 1'b0 ||
                o1_mw !== 1'b0 || o1_mr !== 1'b0 || o1_rd !== 5'd0 ||
                o1_br !== 1'b0 || o1_jal !== 1'b0 || o1_jalr !== 1'b0) begin
                errs++; $display("FAIL illegal_%0d: got v=%b ill=%b rw=%b mw=%b mr=%b rd=%0d want 1/1/0/0/0/0",
                                 k, o1_valid, o1_ill, o1_rw, o1_mw, o1_mr, o1_rd);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_load_use(input logic use3, input int exp_b);
        int  bubbles;
        logic got;
        logic acc;
        do_reset();
        sel = use3;
        out_ready = 1'b1; in_valid = 1'b1; in_instr = I_LW; in_pc = 32'h40;
        @(posedge clk); #1;
        in_instr = I_DEP; in_pc = 32'h44;
        checks++;
        if (s_valid !== 1'b1 || s_rd !== 5'd10) begin
            errs++; $display("FAIL lu%0d_load: got v=%b rd=%0d want 1/10",
                             exp_b, s_valid, s_rd);
        end
        bubbles = 0; got = 1'b0; acc = 1'b0;
        for (int c = 0; c < 12 && !got; c++) begin
            #1;
            if (s_rdy && in_valid) acc = 1'b1;
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
            if (s_valid && s_rd == 5'd11) got = 1'b1;
            else if (!s_valid) bubbles++;
        end
        checks++;
        if (got !== 1'b1) begin
            errs++; $display("FAIL lu%0d_arrive: got %b want 1", exp_b, got);
        end
        checks++;
        if (bubbles != exp_b) begin
            errs++; $display("FAIL lu%0d_bubbles: got %0d want %0d", exp_b, bubbles, exp_b);
        end
        checks++;
        if (s_stall !== 16'(exp_b)) begin
            errs++; $display("FAIL lu%0d_stall: got %0d want %0d", exp_b, s_stall, exp_b);
        end
        in_valid = 1'b0;
        sel = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = I_ADDI; in_pc = 32'h10;
        @(posedge clk); #1;
        in_instr = I_ADD; in_pc = 32'h14;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (o1_in_ready !== 1'b0 || o1_valid !== 1'b1 || o1_pc !== 32'h10 ||
                o1_imm !== 32'hffffffe0 || o1_rd !== 5'd2) begin
                errs++; $display("FAIL bp_hold_%0d: got rdy=%b v=%b pc=%h imm=%h rd=%0d want 0/1/10/ffffffe0/2",
                                 c, o1_in_ready, o1_valid, o1_pc, o1_imm, o1_rd);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (o1_in_ready !== 1'b1) begin
            errs++; $display("FAIL bp_release: got %b want 1", o1_in_ready);
        end
        @(posedge clk); #1;
        in_instr = I_JAL; in_pc = 32'h18;
        checks++;
        if (o1_valid !== 1'b1 || o1_pc !== 32'h14 || o1_rd !== 5'd13) begin
            errs++; $display("FAIL bp_drain1: got v=%b pc=%h rd=%0d want 1/14/13",
                             o1_valid, o1_pc, o1_rd);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (o1_valid !== 1'b1 || o1_pc !== 32'h18 || o1_jal !== 1'b1) begin
            errs++; $display("FAIL bp_drain2: got v=%b pc=%h jal=%b want 1/18/1",
                             o1_valid, o1_pc, o1_jal);
        end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = I_ADD; in_pc = 32'h20;
        @(posedge clk); #1;
        flush = 1'b1; out_ready = 1'b0;
        in_instr = I_ADDI; in_pc = 32'h24;
        #1;
        checks++;
        if (o1_valid !== 1'b1 || o1_in_ready !== 1'b0) begin
            errs++; $display("FAIL flush_pre: got v=%b rdy=%b want 1/0", o1_valid, o1_in_ready);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (o1_valid !== 1'b0) begin
            errs++; $display("FAIL flush_kill: got %b want 0", o1_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (o1_valid !== 1'b1 || o1_pc !== 32'h24) begin
            errs++; $display("FAIL flush_next: got v=%b pc=%h want 1/24", o1_valid, o1_pc);
        end
    endtask

    task automatic test_flush_hold();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = I_LW;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b1; in_instr = I_DEP;
        #1;
        checks++;
        if (o3_in_ready !== 1'b1) begin
            errs++; $display("FAIL flush_hold_ready: got %b want 1", o3_in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (o3_valid !== 1'b1 || o3_rd !== 5'd11) begin
            errs++; $display("FAIL flush_hold_accept: got v=%b rd=%0d want 1/11",
                             o3_valid, o3_rd);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = I_LW;
        @(posedge clk); #1;
        in_instr = I_DEP;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (o3_stall !== 16'd2 || o3_rd !== 5'd10 || o3_mr !== 1'b1) begin
            errs++; $display("FAIL mid_stall: got stall=%0d rd=%0d mr=%b want 2/10/1",
                             o3_stall, o3_rd, o3_mr);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (o3_stall !== 16'd0 || o3_rd !== 5'd0 || o3_mr !== 1'b0 ||
            o3_valid !== 1'b0 || o3_pc !== 32'h0) begin
            errs++; $display("FAIL async_reset: got stall=%0d rd=%0d mr=%b v=%b pc=%h want 0",
                             o3_stall, o3_rd, o3_mr, o3_valid, o3_pc);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        sel = 1'b0;
        test_reset();
        test_rtype();
        test_back_to_back();
        test_shift_sub();
        test_illegal();
        test_load_use(1'b0, 1);
        test_load_use(1'b1, 3);
        test_backpressure();
        test_flush();
        test_flush_hold();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
